uart_tx_fifo: RTL

- Byte FIFO plus strobe sequencer that sits directly upstream of the UART transmitter in the s4x7 diag/debug path.
- Accepts bytes from the diag command/response logic and buffers them.
- Issues single-clock tx_stb/tx_din pairs to the transmitter, one byte per character time, paced by the transmitter's tbre (transmit buffer empty) flag.
- Decouples bursty response generation from the serial line rate.

---
 rtl/diag_pkg.sv | 20 ++
 rtl/uart_tx_fifo_if.sv | 32 +++
 rtl/sync_fifo_mem.sv | 38 +++
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/diag_pkg.sv
// Shared types and default sizing for the diag/debug UART transmit path.
package diag_pkg;

  localparam int DIAG_DEPTH_LOG2 = 4;
  localparam int DIAG_DATA_W     = 8;
  localparam int DIAG_BUSY_TMO   = 3;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_LOW,
    WAIT_HIGH
  } tx_state_e;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side, status and transmitter-side signals of the diag UART transmit FIFO.
interface uart_tx_fifo_if
  import diag_pkg::*;
#(
  parameter int DEPTH_LOG2 = DIAG_DEPTH_LOG2,
  parameter int DATA_W     = DIAG_DATA_W
) ();

  logic [DATA_W-1:0]   wr_data;
  logic                wr_stb;
  logic                flush;
  logic                tx_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic [DATA_W-1:0]   tx_din;
  logic                tx_stb;
  logic                tbre;

  // The master is the surrounding system: command logic plus the transmitter.
  modport master (
    output wr_data, wr_stb, flush, tx_en, tbre,
    input  full, empty, count, overflow, tx_din, tx_stb
  );

  modport slave (
    input  wr_data, wr_stb, flush, tx_en, tbre,
    output full, empty, count, overflow, tx_din, tx_stb
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
module sync_fifo_mem
  import diag_pkg::*;
#(
  parameter int ADDR_W = DIAG_DEPTH_LOG2,
  parameter int DATA_W = DIAG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data holds between reads, so it doubles as the transmitter data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the diag UART transmitter, one strobe per character time
// paced by the transmitter's buffer-empty flag.
module uart_tx_fifo
  import diag_pkg::*;
#(
  parameter int DEPTH_LOG2 = DIAG_DEPTH_LOG2,
  parameter int DATA_W     = DIAG_DATA_W,
  parameter int BUSY_TMO   = DIAG_BUSY_TMO
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int TMO_W = cnt_width(BUSY_TMO);

  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(2**DEPTH_LOG2);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [TMO_W-1:0]      TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(BUSY_TMO - 1);

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  tx_state_e             state_q, state_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  tx_stb_q, tx_stb_d;
  logic                  pop;
  logic                  wr_accept;
  logic [DATA_W-1:0]     rd_data;

  // Pop only from registered empty, so a byte written this edge waits at least one clock.
  assign pop       = (state_q == IDLE) && !empty_q && bus.tx_en && bus.tbre;
  assign wr_accept = bus.wr_stb && !bus.flush && (!full_q || pop);

  sync_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_accept),
    .waddr_i (wptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (pop),
    .raddr_i (rptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      if (wr_accept && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!wr_accept && pop) begin
        count_d = count_q - CNT_ONE;
      end
      if (bus.wr_stb && full_q && !pop) begin
        overflow_d = 1'b1;
      end
    end
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  // Flush leaves the sequencer alone so an in-flight byte completes without a repeat strobe.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    tx_stb_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_stb_d = 1'b1;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        tmo_d   = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.tbre) begin
          state_d = WAIT_HIGH;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
          if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (bus.tbre) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      tmo_q      <= '0;
      tx_stb_q   <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      tx_stb_q   <= tx_stb_d;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_stb   = tx_stb_q;
  assign bus.tx_din   = rd_data;

endmodule
